// File: rtl/tx_logic_2_pkg.sv
// tx_logic_2 shared definitions: default geometry, no-port sentinel and
// the per-port slice helper shared with the receive side.
package tx_logic_2_pkg;

  localparam int DEF_SIZE       = 8;
  localparam int DEF_PORT_COUNT = 5;
  localparam int DEF_DEST_LSB   = 0;
  localparam int DEF_DEST_WIDTH = 3;

  localparam int NO_PORT = -1;

  function automatic int slice_lsb(input int k, input int size);
    return size * k;
  endfunction

endpackage

// File: rtl/tx_port_channel.sv
// tx_port_channel: one downstream link, holding a request toggle and the
// data word it guards; idle while the request matches the acknowledge.
module tx_port_channel #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue,
  input  logic [SIZE-1:0] item,
  input  logic            ack,
  output logic            req,
  output logic [SIZE-1:0] data,
  output logic            idle
);

  // Data and request toggle move together on an issue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req  <= 1'b0;
      data <= '0;
    end else if (issue) begin
      req  <= ~req;
      data <= item;
    end
  end

  assign idle = (req == ack);

endmodule

// File: rtl/tx_logic_2.sv
// tx_logic_2: pops the output fifo and forwards items by toggle handshake.
// Define TX_LOGIC_STATS_EN to add sent_count / drop_count outputs.
module tx_logic_2
  import tx_logic_2_pkg::*;
#(
  parameter int ID         = -1,
  parameter int SIZE       = DEF_SIZE,
  parameter int PORT_COUNT = DEF_PORT_COUNT,
  parameter int DEST_LSB   = DEF_DEST_LSB,
  parameter int DEST_WIDTH = DEF_DEST_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       fifo_read,
  input  logic                       fifo_empty,
  input  logic [SIZE-1:0]            fifo_item_out,
  output logic [PORT_COUNT-1:0]      tx_req,
  input  logic [PORT_COUNT-1:0]      tx_ack,
  output logic [SIZE*PORT_COUNT-1:0] tx_data
`ifdef TX_LOGIC_STATS_EN
  ,
  output logic [15:0]                sent_count,
  output logic [15:0]                drop_count
`endif
);

  logic [DEST_WIDTH-1:0] dest;
  logic                  head_valid;
  int                    head_port;
  logic                  head_idle;
  logic                  issue;
  logic                  drop;
  logic [PORT_COUNT-1:0] port_idle;
  logic [PORT_COUNT-1:0] port_issue;
  logic                  unused_id;

  assign unused_id  = (ID == 0);
  assign dest       = fifo_item_out[DEST_LSB +: DEST_WIDTH];
  assign head_valid = (int'(dest) < PORT_COUNT);

  // Decode the head's port and whether that port can take it now.
  always_comb begin
    head_port = NO_PORT;
    head_idle = 1'b0;
    if (head_valid) head_port = int'(dest);
    for (int p = 0; p < PORT_COUNT; p++) begin
      if (head_port == p) head_idle = port_idle[p];
    end
  end

  // Issue, drop or block the head; reset suppresses the pop strobe.
  always_comb begin
    issue      = 1'b0;
    drop       = 1'b0;
    port_issue = '0;
    if (!reset && !fifo_empty) begin
      drop  = !head_valid;
      issue = head_valid && head_idle;
      for (int p = 0; p < PORT_COUNT; p++) begin
        port_issue[p] = issue && (head_port == p);
      end
    end
    fifo_read = issue || drop;
  end

  for (genvar k = 0; k < PORT_COUNT; k++) begin : g_port
    tx_port_channel #(
      .SIZE (SIZE)
    ) u_chan (
      .clk   (clk),
      .reset (reset),
      .issue (port_issue[k]),
      .item  (fifo_item_out),
      .ack   (tx_ack[k]),
      .req   (tx_req[k]),
      .data  (tx_data[slice_lsb(k, SIZE) +: SIZE]),
      .idle  (port_idle[k])
    );
  end

`ifdef TX_LOGIC_STATS_EN
  // Free-running issue and drop counters, wrapping at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sent_count <= '0;
      drop_count <= '0;
    end else begin
      if (issue) sent_count <= sent_count + 16'd1;
      if (drop)  drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tx_logic_2.sv
// tb_tx_logic_2: directed checks of issue, block, drop, ordering and
// asynchronous reset for tx_logic_2 with a small fifo model.
module tb_tx_logic_2;

  logic        clk;
  logic        reset;
  logic        fifo_read;
  logic        fifo_empty;
  logic [7:0]  fifo_item_out;
  logic [4:0]  tx_req;
  logic [4:0]  tx_ack;
  logic [39:0] tx_data;
`ifdef TX_LOGIC_STATS_EN
  logic [15:0] sent_count;
  logic [15:0] drop_count;
`endif

  int checks;
  int errors;

  logic [7:0] mem [16];
  logic [3:0] head;
  logic [3:0] tail;

  assign fifo_empty    = (head == tail);
  assign fifo_item_out = mem[head];

  tx_logic_2 dut (
    .clk           (clk),
    .reset         (reset),
    .fifo_read     (fifo_read),
    .fifo_empty    (fifo_empty),
    .fifo_item_out (fifo_item_out),
    .tx_req        (tx_req),
    .tx_ack        (tx_ack),
    .tx_data       (tx_data)
`ifdef TX_LOGIC_STATS_EN
    ,
    .sent_count    (sent_count),
    .drop_count    (drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_read) head <= head + 4'd1;
  end

  task automatic push(input logic [7:0] v);
    mem[tail] = v;
    tail = tail + 4'd1;
  endtask

  task automatic test_reset;
    reset  = 1'b1;
    tx_ack = '0;
    head   = '0;
    tail   = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (tx_req !== 5'b0) begin
      errors++;
      $display("FAIL reset_req got %b want %b", tx_req, 5'b0);
    end
    checks++;
    if (tx_data !== 40'h0) begin
      errors++;
      $display("FAIL reset_data got %h want %h", tx_data, 40'h0);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (fifo_read !== 1'b0) begin
        errors++;
        $display("FAIL empty_read cyc %0d got %b want 0", i, fifo_read);
      end
    end
  endtask

  task automatic test_issue_block;
    @(negedge clk);
    push(8'h02);
    #1;
    checks++;
    if (fifo_read !== 1'b1) begin
      errors++;
      $display("FAIL issue_read got %b want 1", fifo_read);
    end
    @(posedge clk);
    #1;
    checks++;
    if (tx_req !== 5'b00100) begin
      errors++;
      $display("FAIL issue_req got %b want %b", tx_req, 5'b00100);
    end
    checks++;
    if (tx_data[23:16] !== 8'h02) begin
      errors++;
      $display("FAIL issue_data got %h want 02", tx_data[23:16]);
    end
    checks++;
    if (fifo_read !== 1'b0) begin
      errors++;
      $display("FAIL issue_once got %b want 0", fifo_read);
    end
    @(negedge clk);
    push(8'h12);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (fifo_read !== 1'b0) begin
        errors++;
        $display("FAIL block_read cyc %0d got %b want 0", i, fifo_read);
      end
      @(negedge clk);
    end
    tx_ack[2] = 1'b1;
    #1;
    checks++;
    if (fifo_read !== 1'b1) begin
      errors++;
      $display("FAIL ack_issue_read got %b want 1", fifo_read);
    end
    @(posedge clk);
    #1;
    checks++;
    if (tx_req !== 5'b00000) begin
      errors++;
      $display("FAIL ack_issue_req got %b want %b", tx_req, 5'b0);
    end
    checks++;
    if (tx_data[23:16] !== 8'h12) begin
      errors++;
      $display("FAIL ack_issue_data got %h want 12", tx_data[23:16]);
    end
    @(negedge clk);
    tx_ack[2] = 1'b0;
  endtask

  task automatic test_multi_port;
    @(negedge clk);
    push(8'h00);
    push(8'h01);
    push(8'h03);
    push(8'h04);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (fifo_read !== 1'b1) begin
        errors++;
        $display("FAIL multi_read cyc %0d got %b want 1", i, fifo_read);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (tx_req !== 5'b11011) begin
      errors++;
      $display("FAIL multi_req got %b want %b", tx_req, 5'b11011);
    end
    checks++;
    if (tx_data !== 40'h04_03_12_01_00) begin
      errors++;
      $display("FAIL multi_data got %h want %h", tx_data, 40'h04_03_12_01_00);
    end
    @(negedge clk);
    tx_ack = 5'b11011;
  endtask

  task automatic test_drop;
    @(negedge clk);
    push(8'h07);
    #1;
    checks++;
    if (fifo_read !== 1'b1) begin
      errors++;
      $display("FAIL drop_read got %b want 1", fifo_read);
    end
    @(posedge clk);
    #1;
    checks++;
    if (tx_req !== 5'b11011) begin
      errors++;
      $display("FAIL drop_req got %b want %b", tx_req, 5'b11011);
    end
    checks++;
    if (tx_data !== 40'h04_03_12_01_00) begin
      errors++;
      $display("FAIL drop_data got %h want %h", tx_data, 40'h04_03_12_01_00);
    end
    checks++;
    if (fifo_read !== 1'b0) begin
      errors++;
      $display("FAIL drop_once got %b want 0", fifo_read);
    end
`ifdef TX_LOGIC_STATS_EN
    checks++;
    if (drop_count !== 16'd1) begin
      errors++;
      $display("FAIL drop_count got %0d want 1", drop_count);
    end
    checks++;
    if (sent_count !== 16'd6) begin
      errors++;
      $display("FAIL sent_count got %0d want 6", sent_count);
    end
`endif
  endtask

  task automatic test_in_order;
    @(negedge clk);
    push(8'h01);
    @(negedge clk);
    push(8'h09);
    push(8'h08);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (fifo_read !== 1'b0) begin
        errors++;
        $display("FAIL order_block cyc %0d got %b want 0", i, fifo_read);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (tx_req !== 5'b11001 || tx_data[7:0] !== 8'h00) begin
      errors++;
      $display("FAIL order_hold got %b/%h want %b/00", tx_req, tx_data[7:0], 5'b11001);
    end
    @(negedge clk);
    tx_ack[1] = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (tx_req !== 5'b11011 || tx_data[15:8] !== 8'h09) begin
      errors++;
      $display("FAIL order_first got %b/%h want %b/09", tx_req, tx_data[15:8], 5'b11011);
    end
    @(posedge clk);
    #1;
    checks++;
    if (tx_req !== 5'b11010 || tx_data[7:0] !== 8'h08) begin
      errors++;
      $display("FAIL order_second got %b/%h want %b/08", tx_req, tx_data[7:0], 5'b11010);
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    push(8'h03);
    @(negedge clk);
    #1;
    checks++;
    if (tx_req !== 5'b10010) begin
      errors++;
      $display("FAIL pre_reset_req got %b want %b", tx_req, 5'b10010);
    end
    #1;
    reset  = 1'b1;
    tx_ack = '0;
    push(8'h04);
    #1;
    checks++;
    if (tx_req !== 5'b0 || tx_data !== 40'h0) begin
      errors++;
      $display("FAIL async_reset got %b/%h want 0/0", tx_req, tx_data);
    end
    checks++;
    if (fifo_read !== 1'b0) begin
      errors++;
      $display("FAIL reset_read got %b want 0", fifo_read);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (fifo_read !== 1'b1) begin
      errors++;
      $display("FAIL cold_read got %b want 1", fifo_read);
    end
    @(posedge clk);
    #1;
    checks++;
    if (tx_req !== 5'b10000 || tx_data !== 40'h04_00_00_00_00) begin
      errors++;
      $display("FAIL cold_issue got %b/%h want %b/%h", tx_req, tx_data, 5'b10000, 40'h04_00_00_00_00);
    end
`ifdef TX_LOGIC_STATS_EN
    checks++;
    if (sent_count !== 16'd1 || drop_count !== 16'd0) begin
      errors++;
      $display("FAIL cold_stats got %0d/%0d want 1/0", sent_count, drop_count);
    end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_issue_block();
    test_multi_port();
    test_drop();
    test_in_order();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
